ifetch_unit: RTL



---
 rtl/ifetch_unit_pkg.sv | 20 ++
 rtl/ifetch_queue.sv | 55 +++++
 rtl/ifetch_unit.sv | 102 ++++++++++
 3 files changed

// File: rtl/ifetch_unit_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package ifetch_unit_pkg;

  localparam int unsigned IFQ_DEPTH_DEF = 2;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0013;

  // One fetch-queue slot: fetched PC, returned word, misaligned-fetch marker flag
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } ifq_entry_t;

  typedef enum logic {
    IF_RUN,
    IF_FAULT
  } ifetch_state_t;

endpackage

// File: rtl/ifetch_queue.sv
// Small synchronous FIFO of fetch entries with flush; head is read combinationally.
module ifetch_queue
  import ifetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = IFQ_DEPTH_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  ifq_entry_t push_data,
  input  logic       pop,
  output ifq_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  ifq_entry_t  mem_q [DEPTH];
  logic        do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer and storage update; flush discards all entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: owns the fetch PC, drives instruction memory, queues
// {pc, instruction} for decode and handles redirects and misaligned targets.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int unsigned IFQ_DEPTH = IFQ_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instruction,
  output logic        if_misaligned
);

  ifetch_state_t state_q;
  logic [31:0]   fetch_pc_q;
  logic          marker_pending_q;

  logic          push, pop;
  logic          q_full, q_empty;
  ifq_entry_t    push_data, head;

  assign imem_pc        = fetch_pc_q;
  assign if_valid       = !q_empty;
  assign pop            = if_valid && if_ready;
  assign if_pc          = head.pc;
  assign if_instruction = head.instr;
  assign if_misaligned  = head.misaligned;

  // Push decision: redirect suppresses pushes; FAULT pushes only the one marker
  always_comb begin
    push      = 1'b0;
    push_data = '{pc: fetch_pc_q, instr: imem_instruction, misaligned: 1'b0};
    if (!redirect_valid) begin
      case (state_q)
        IF_RUN:   push = !q_full || pop;
        IF_FAULT: begin
          if (marker_pending_q) begin
            push      = 1'b1;
            push_data = '{pc: fetch_pc_q, instr: INSTR_NOP, misaligned: 1'b1};
          end
        end
        default:  push = 1'b0;
      endcase
    end
  end

  // PC register and RUN/FAULT state machine
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IF_RUN;
      fetch_pc_q       <= RESET_PC;
      marker_pending_q <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_q <= redirect_pc;
      if (redirect_pc[1:0] == 2'b00) begin
        state_q          <= IF_RUN;
        marker_pending_q <= 1'b0;
      end else begin
        state_q          <= IF_FAULT;
        marker_pending_q <= 1'b1;
      end
    end else begin
      case (state_q)
        IF_RUN: begin
          if (push) begin
            fetch_pc_q <= fetch_pc_q + 32'd4;
          end
        end
        IF_FAULT: begin
          // imem_pc holds the faulting target; only a redirect leaves FAULT
          if (marker_pending_q) begin
            marker_pending_q <= 1'b0;
          end
        end
        default: state_q <= IF_RUN;
      endcase
    end
  end

  ifetch_queue #(
    .DEPTH (IFQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule
